wb_intercon: RTL and testbench
==============================

WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 SHALL have parameter NUM_M, default 2, number of Wishbone masters (1..4).
REQ-002 SHALL have parameter NUM_S, default 4, number of Wishbone slaves (1..8).
REQ-003 SHALL have parameter S_BASE, default {32'h00000000, 32'h40000000, 32'h70000000, 32'h70010000}, NUM_S x 32 flat base addresses; slave i at bits [32i+31:32i].
REQ-004 SHALL have parameter S_MASK, default {32'hF0000000, 32'hF0000000, 32'hFFFF0000, 32'hFFFF0000}, NUM_S x 32 flat decode masks.
REQ-005 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (1..65535).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 m_cyc_i, m_stb_i, m_we_i  in  NUM_M each  per-master cycle, strobe, write.
REQ-009 m_adr_i, m_dat_i  in  NUM_M*32 each  per-master address, write data.
REQ-010 m_sel_i  in  NUM_M*4  per-master byte selects.
REQ-011 m_dat_o  out  NUM_M*32  read data; every slice carries the routed slave data.
REQ-012 m_ack_o, m_err_o, m_rty_o  out  NUM_M each  per-master responses.
REQ-013 s_cyc_o, s_stb_o  out  NUM_S each  per-slave cycle, strobe.
REQ-014 s_we_o 1, s_adr_o 32, s_dat_o 32, s_sel_o 4  out  shared copies from the granted master.
REQ-015 s_dat_i  in  NUM_S*32; s_ack_i, s_err_i, s_rty_i  in  NUM_S each  slave responses.
REQ-016 grant_o  out  NUM_M  one-hot current owner (zero when idle).

Function
REQ-017 Arbiter SHALL be a two-state FSM: IDLE, OWNED.
REQ-018 IDLE: if any m_cyc_i is set, SHALL grant the first requester after the last owner in ascending wrap-around order (round-robin) and go to OWNED at the next edge.
REQ-019 OWNED: grant SHALL hold while the owner's m_cyc_i=1 (bus lock); when it samples 0, SHALL return to IDLE at that edge; a new grant therefore needs at least one IDLE cycle.
REQ-020 Requests from non-owners SHALL be ignored and see ack/err/rty=0.
REQ-021 Decode SHALL be combinational on the owner's address: slave i hits if (adr & MASK_i) == (BASE_i & MASK_i); lowest index wins on overlap.
REQ-022 s_cyc_o[i]/s_stb_o[i] SHALL equal owner cyc/stb AND hit_i AND state==OWNED; all other slave strobes 0.
REQ-023 Slave ack/err/rty/dat of the hit slave SHALL route combinationally to the owner (zero latency added).
REQ-024 Owner stb=1 with no hit SHALL assert m_err_o of the owner for exactly one cycle, registered, one cycle after stb is sampled; not re-asserted in the cycle following an err.
REQ-025 Routed err and decode err in the same cycle SHALL yield a single err.
REQ-026 Owner stb dropped before decode err is issued SHALL cancel the err.

Reset
REQ-027 rst_i=1 SHALL immediately force state IDLE, grant_o=0, all s_cyc_o/s_stb_o=0, all m_ack_o/m_err_o/m_rty_o=0, round-robin pointer = NUM_M-1 (master 0 wins first), watchdog count 0.
REQ-028 Reset during OWNED SHALL abort the transfer with no response to any master.

Configuration
REQ-029 Macro WB_INTERCON_TIMEOUT_EN defined: a 16-bit counter SHALL count cycles with owner stb=1 and no routed ack/err/rty, clear on any response, stb=0 or IDLE; on reaching TIMEOUT it SHALL assert owner m_err_o for one cycle, drop s_stb_o of the stalled slave that cycle, and clear.
REQ-030 Macro undefined: no counter SHALL be synthesised; a non-responding slave stalls the owner indefinitely.

Verification
REQ-031 Master 0 reads 0x70000004, slave 2 acks same cycle with 0xDEADBEEF -> m_dat_o slice 0 = 0xDEADBEEF, m_ack_o[0]=1 that cycle, s_stb_o=4'b0100.
REQ-032 Masters 0 and 1 raise cyc together after reset, both hold 3 transfers, repeat -> grant order 0,1,0,1; one IDLE cycle between owners; no overlap in grant_o.
REQ-033 Master 1 strobes 0x90000000 -> m_err_o[1] pulses one cycle after stb, all s_stb_o=0.
REQ-034 With WB_INTERCON_TIMEOUT_EN, TIMEOUT=8, slave 0 never acks -> m_err_o pulse after 8 stalled cycles; without the macro -> no err after 1000 cycles.
REQ-035 rst_i raised mid-burst while master 0 owns slave 1 -> s_cyc_o=0, grant_o=0 in the same cycle; after release master 0 re-granted first.

Source files
------------

// File: rtl/wb_intercon.sv
// Wishbone shared-bus interconnect: round-robin arbiter, address decoder, response router.
// Optional watchdog under `WB_INTERCON_TIMEOUT_EN` aborts transfers to non-responding slaves.
module wb_intercon #(
    parameter int NUM_M = 2,
    parameter int NUM_S = 4,
    parameter logic [NUM_S*32-1:0] S_BASE = {32'h7001_0000, 32'h7000_0000,
                                             32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_S*32-1:0] S_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                             32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*32-1:0] m_adr_i,
    input  logic [NUM_M*32-1:0] m_dat_i,
    input  logic [NUM_M*4-1:0]  m_sel_i,
    output logic [NUM_M*32-1:0] m_dat_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_M-1:0]    m_rty_o,
    output logic [NUM_S-1:0]    s_cyc_o,
    output logic [NUM_S-1:0]    s_stb_o,
    output logic                s_we_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    input  logic [NUM_S*32-1:0] s_dat_i,
    input  logic [NUM_S-1:0]    s_ack_i,
    input  logic [NUM_S-1:0]    s_err_i,
    input  logic [NUM_S-1:0]    s_rty_i,
    output logic [NUM_M-1:0]    grant_o
);

    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [MW-1:0]   own_q, own_d;
    logic [MW-1:0]   ptr_q, ptr_d;
    logic            derr_q, derr_d;

    logic            owned;
    logic            o_cyc, o_stb;
    logic [31:0]     o_adr;
    logic [NUM_S-1:0] hit;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic            to_fire;
    logic            act;
    logic            r_ack, r_err, r_rty;
    logic [31:0]     r_dat;
    logic            derr_o;

    assign owned = (state_q == OWNED);

    // Select the current owner's request signals
    always_comb begin
        o_cyc   = m_cyc_i[own_q];
        o_stb   = m_stb_i[own_q];
        o_adr   = m_adr_i[int'(own_q)*32 +: 32];
        s_we_o  = m_we_i[own_q];
        s_adr_o = o_adr;
        s_dat_o = m_dat_i[int'(own_q)*32 +: 32];
        s_sel_o = m_sel_i[int'(own_q)*4 +: 4];
    end

    // Address decode, lowest slave index wins on overlap
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (!hit_any &&
                ((o_adr & S_MASK[i*32 +: 32]) ==
                 (S_BASE[i*32 +: 32] & S_MASK[i*32 +: 32]))) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Slave strobes and routed responses; a watchdog abort drops the strobe
    always_comb begin
        s_cyc_o = (owned && o_cyc) ? hit : '0;
        s_stb_o = (owned && o_stb && !to_fire) ? hit : '0;
        act     = owned && o_stb && hit_any && !to_fire;
        r_ack   = act && s_ack_i[hit_idx];
        r_err   = act && s_err_i[hit_idx];
        r_rty   = act && s_rty_i[hit_idx];
        r_dat   = hit_any ? s_dat_i[int'(hit_idx)*32 +: 32] : '0;
        derr_o  = derr_q && owned && o_stb;
        m_dat_o = {NUM_M{r_dat}};
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (owned) begin
            m_ack_o[own_q] = r_ack;
            m_err_o[own_q] = r_err || derr_o || to_fire;
            m_rty_o[own_q] = r_rty;
        end
    end

    // Arbiter next state: round-robin grant from IDLE, hold while owner keeps cyc
    always_comb begin
        int idx;
        logic found;
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        unique case (state_q)
            IDLE: begin
                for (int k = 1; k <= NUM_M; k++) begin
                    idx = (int'(ptr_q) + k) % NUM_M;
                    if (!found && m_cyc_i[idx]) begin
                        found        = 1'b1;
                        own_d        = MW'(idx);
                        ptr_d        = MW'(idx);
                        grant_d      = '0;
                        grant_d[idx] = 1'b1;
                        state_d      = OWNED;
                    end
                end
            end
            OWNED: begin
                if (!o_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        derr_d = owned && o_cyc && o_stb && !hit_any && !derr_q;
    end

    // Arbiter and decode-error state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= MW'(NUM_M - 1);
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            derr_q  <= derr_d;
        end
    end

    assign grant_o = grant_q;

`ifdef WB_INTERCON_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        resp;

    assign resp    = s_ack_i[hit_idx] || s_err_i[hit_idx] || s_rty_i[hit_idx];
    assign to_fire = owned && o_stb && hit_any && (cnt_q == 16'(TIMEOUT));

    // Stall counter: counts strobed cycles with no slave response
    always_comb begin
        if (to_fire || !owned || !o_stb || !hit_any || resp)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 16'd1;
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;

    assign to_fire        = 1'b0;
    assign unused_timeout = |16'(TIMEOUT);
`endif

endmodule

// File: tb/tb_wb_intercon.sv
// Directed self-checking bench for wb_intercon (2 masters, 4 slaves, default map).
// Covers single read, round-robin, decode error and its cancel, reset abort, watchdog.
module tb_wb_intercon;

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   m_cyc = '0;
    logic [1:0]   m_stb = '0;
    logic [1:0]   m_we = '0;
    logic [63:0]  m_adr = '0;
    logic [63:0]  m_dat = '0;
    logic [7:0]   m_sel = '0;
    logic [63:0]  m_dat_o;
    logic [1:0]   m_ack_o, m_err_o, m_rty_o;
    logic [3:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic [127:0] s_dat = '0;
    logic [3:0]   s_ack = '0;
    logic [3:0]   s_err = '0;
    logic [3:0]   s_rty = '0;
    logic [1:0]   grant_o;

    int n_chk = 0;
    int n_fail = 0;

    wb_intercon #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        int errs;

        #1 rst = 1'b1;
        #1;
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_scyc", 64'(s_cyc_o), 64'h0);
        chk("rst_merr", 64'(m_err_o), 64'h0);
        step();
        step();
        rst = 1'b0;

        // Single read from slave 2
        m_cyc = 2'b01; m_stb = 2'b01;
        m_adr[31:0] = 32'h7000_0004;
        s_ack = 4'b0100;
        s_dat[95:64] = 32'hDEAD_BEEF;
        #1;
        chk("idle_grant", 64'(grant_o), 64'h0);
        chk("idle_ack", 64'(m_ack_o), 64'h0);
        step();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        m_adr[63:32] = 32'h7000_0004;
        #1;
        chk("rd_grant", 64'(grant_o), 64'h1);
        chk("rd_sstb", 64'(s_stb_o), 64'h4);
        chk("rd_scyc", 64'(s_cyc_o), 64'h4);
        chk("rd_ack", 64'(m_ack_o), 64'h1);
        chk("rd_dat0", 64'(m_dat_o[31:0]), 64'hDEAD_BEEF);
        chk("rd_dat1", 64'(m_dat_o[63:32]), 64'hDEAD_BEEF);
        chk("rd_sadr", 64'(s_adr_o), 64'h7000_0004);
        step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        chk("drop_grant", 64'(grant_o), 64'h1);
        chk("drop_sstb", 64'(s_stb_o), 64'h0);
        chk("drop_ack", 64'(m_ack_o), 64'h0);
        step();
        chk("gap_grant", 64'(grant_o), 64'h0);
        step();
        chk("m1_grant", 64'(grant_o), 64'h2);
        chk("m1_ack", 64'(m_ack_o), 64'h2);

        // Decode error for master 1
        step();
        m_adr[63:32] = 32'h9000_0000;
        #1;
        chk("derr_sstb", 64'(s_stb_o), 64'h0);
        chk("derr_early", 64'(m_err_o), 64'h0);
        step();
        chk("derr_pulse", 64'(m_err_o), 64'h2);
        step();
        chk("derr_once", 64'(m_err_o), 64'h0);
        m_cyc = 2'b00; m_stb = 2'b00;
        step();
        chk("derr_idle", 64'(grant_o), 64'h0);

        // Round robin: both masters, three transfers each, four rounds
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr = {32'h7000_0004, 32'h7000_0004};
        #1;
        chk("rr_idle_sstb", 64'(s_stb_o), 64'h0);
        for (int r = 0; r < 4; r++) begin
            exp_g = 2'(1 << (r % 2));
            for (int t = 0; t < 3; t++) begin
                step();
                chk("rr_grant", 64'(grant_o), 64'(exp_g));
                chk("rr_ack", 64'(m_ack_o), 64'(exp_g));
            end
            step();
            m_cyc[r % 2] = 1'b0; m_stb[r % 2] = 1'b0;
            #1;
            chk("rr_release", 64'(grant_o), 64'(exp_g));
            step();
            chk("rr_gap", 64'(grant_o), 64'h0);
            m_cyc[r % 2] = 1'b1; m_stb[r % 2] = 1'b1;
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        step();
        chk("rr_done", 64'(grant_o), 64'h0);

        // Decode error cancelled by early strobe drop
        m_cyc = 2'b01; m_stb = 2'b01;
        m_adr[31:0] = 32'h9000_0000;
        step();
        chk("cancel_grant", 64'(grant_o), 64'h1);
        step();
        m_stb[0] = 1'b0;
        #1;
        chk("cancel_err", 64'(m_err_o), 64'h0);

        // Reset mid-burst on slave 1
        step();
        m_adr[31:0] = 32'h4000_0010;
        m_stb[0] = 1'b1;
        s_ack = 4'b0010;
        #1;
        chk("burst_scyc", 64'(s_cyc_o), 64'h2);
        chk("burst_ack", 64'(m_ack_o), 64'h1);
        rst = 1'b1;
        #1;
        chk("arst_scyc", 64'(s_cyc_o), 64'h0);
        chk("arst_grant", 64'(grant_o), 64'h0);
        chk("arst_ack", 64'(m_ack_o), 64'h0);
        m_cyc = 2'b11; m_stb = 2'b11;
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_grant", 64'(grant_o), 64'h1);
        m_cyc = 2'b00; m_stb = 2'b00;
        step();
        step();
        chk("post_rst_idle", 64'(grant_o), 64'h0);

        // Non-responding slave 0
        s_ack = 4'b0000;
        m_adr[31:0] = 32'h0000_0010;
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
`ifdef WB_INTERCON_TIMEOUT_EN
        for (int i = 1; i <= TMO; i++) begin
            chk("tmo_wait_err", 64'(m_err_o), 64'h0);
            chk("tmo_wait_stb", 64'(s_stb_o), 64'h1);
            step();
        end
        chk("tmo_err", 64'(m_err_o), 64'h1);
        chk("tmo_stb_drop", 64'(s_stb_o), 64'h0);
        step();
        chk("tmo_err_once", 64'(m_err_o), 64'h0);
        chk("tmo_stb_back", 64'(s_stb_o), 64'h1);
`else
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (m_err_o != 2'b00) errs++;
            step();
        end
        chk("stall_no_err", 64'(errs), 64'h0);
        chk("stall_stb", 64'(s_stb_o), 64'h1);
        chk("stall_grant", 64'(grant_o), 64'h1);
`endif
        m_cyc = 2'b00; m_stb = 2'b00;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
